// File: rtl/wt_cache_pkg.sv
// wt_cache_pkg: shared data-cache geometry and read-arbiter constants
package wt_cache_pkg;
  localparam int DCACHE_OFFSET_WIDTH = 4;
  localparam int DCACHE_CL_IDX_WIDTH = 8;
  localparam int DCACHE_TAG_WIDTH = 20;
  localparam int DCACHE_RD_ARB_STARVE_CNT = 15;
endpackage

// File: rtl/wt_dcache_rr_pick.sv
// wt_dcache_rr_pick: first requester at or above ptr_i, wrapping, as one-hot and index
module wt_dcache_rr_pick #(
  parameter int N = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [PW-1:0] idx_o
);
  always_comb begin
    idx_o = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req_i[(int'(ptr_i) + k) % N]) idx_o = PW'((int'(ptr_i) + k) % N);
    onehot_o = |req_i ? N'(1) << idx_o : '0;
  end
endmodule

// File: rtl/wt_dcache_rd_arb.sv
// wt_dcache_rd_arb: round-robin read-port arbiter for the data cache memory.
// Define WT_DCACHE_RD_ARB_STARVE_EN to add per-port starvation counters.
module wt_dcache_rd_arb
  import wt_cache_pkg::*;
#(
  parameter int NumPorts = 3,
  parameter int StarveCnt = DCACHE_RD_ARB_STARVE_CNT
) (
  input  logic                                             clk_i,
  input  logic                                             rst_i,
  input  logic [NumPorts-1:0]                              rd_req_i,
  input  logic [NumPorts-1:0]                              rd_tag_only_i,
  input  logic [NumPorts-1:0][DCACHE_CL_IDX_WIDTH-1:0]     rd_idx_i,
  input  logic [NumPorts-1:0][DCACHE_OFFSET_WIDTH-1:0]     rd_off_i,
  input  logic [NumPorts-1:0][DCACHE_TAG_WIDTH-1:0]        rd_tag_i,
  output logic [NumPorts-1:0]                              rd_ack_o,
  output logic                                             mem_req_o,
  output logic                                             mem_tag_only_o,
  output logic [DCACHE_CL_IDX_WIDTH-1:0]                   mem_idx_o,
  output logic [DCACHE_OFFSET_WIDTH-1:0]                   mem_off_o,
  output logic [DCACHE_TAG_WIDTH-1:0]                      mem_tag_o,
  input  logic                                             mem_ack_i
);
  localparam int PW = $clog2(NumPorts);
  logic [PW-1:0] rr_ptr_d, rr_ptr_q, win, rr_idx;
  logic [NumPorts-1:0] ack_d, ack_q, rr_oh, win_oh;
  logic [DCACHE_TAG_WIDTH-1:0] tag_mux;
  logic busy;
  wt_dcache_rr_pick #(.N(NumPorts), .PW(PW)) u_rr (
    .req_i(rd_req_i), .ptr_i(rr_ptr_q), .onehot_o(rr_oh), .idx_o(rr_idx)
  );
`ifdef WT_DCACHE_RD_ARB_STARVE_EN
  logic [7:0] cnt_d [NumPorts];
  logic [7:0] cnt_q [NumPorts];
  logic [NumPorts-1:0] starve, st_oh;
  logic [PW-1:0] st_idx;
  always_comb
    for (int i = 0; i < NumPorts; i++) begin
      starve[i] = rd_req_i[i] && cnt_q[i] == 8'(StarveCnt);
      cnt_d[i] = (!rd_req_i[i] || rd_ack_o[i]) ? '0 : starve[i] ? cnt_q[i] : cnt_q[i] + 8'd1;
    end
  // starved ports override round-robin, lowest index first
  wt_dcache_rr_pick #(.N(NumPorts), .PW(PW)) u_starve (
    .req_i(starve), .ptr_i('0), .onehot_o(st_oh), .idx_o(st_idx)
  );
  assign win = |starve ? st_idx : rr_idx;
  assign win_oh = |starve ? st_oh : rr_oh;
  always_ff @(posedge clk_i)
    if (rst_i) cnt_q <= '{default: '0};
    else cnt_q <= cnt_d;
`else
  assign win = rr_idx;
  assign win_oh = rr_oh;
`endif
  assign busy = |rd_req_i && !rst_i;
  always_comb begin
    mem_req_o = busy;
    rd_ack_o = (mem_ack_i && busy) ? win_oh : '0;
    mem_tag_only_o = busy ? rd_tag_only_i[win] : 1'b0;
    mem_idx_o = busy ? rd_idx_i[win] : '0;
    mem_off_o = busy ? rd_off_i[win] : '0;
    rr_ptr_d = |rd_ack_o ? (win == PW'(NumPorts - 1) ? '0 : win + PW'(1)) : rr_ptr_q;
    ack_d = rd_ack_o;
    tag_mux = '0;
    for (int i = 0; i < NumPorts; i++) if (ack_q[i]) tag_mux = tag_mux | rd_tag_i[i];
    mem_tag_o = rst_i ? '0 : tag_mux;
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      rr_ptr_q <= '0;
      ack_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      ack_q <= ack_d;
    end
endmodule

// File: tb/tb_wt_dcache_rd_arb.sv
// tb_wt_dcache_rd_arb: directed vectors for the data-cache read arbiter
module tb_wt_dcache_rd_arb;
  import wt_cache_pkg::*;
  logic clk = 0, rst;
  logic [2:0] rd_req, rd_tag_only, rd_ack;
  logic [2:0][DCACHE_CL_IDX_WIDTH-1:0] rd_idx;
  logic [2:0][DCACHE_OFFSET_WIDTH-1:0] rd_off;
  logic [2:0][DCACHE_TAG_WIDTH-1:0] rd_tag;
  logic mem_req, mem_tag_only, mem_ack;
  logic [DCACHE_CL_IDX_WIDTH-1:0] mem_idx;
  logic [DCACHE_OFFSET_WIDTH-1:0] mem_off;
  logic [DCACHE_TAG_WIDTH-1:0] mem_tag;
  int nvec = 0, nerr = 0;
`ifdef WT_DCACHE_RD_ARB_STARVE_EN
  localparam logic [2:0] STARVE_WIN = 3'b100;
`else
  localparam logic [2:0] STARVE_WIN = 3'b001;
`endif
  wt_dcache_rd_arb #(.NumPorts(3), .StarveCnt(3)) dut (
    .clk_i(clk), .rst_i(rst), .rd_req_i(rd_req), .rd_tag_only_i(rd_tag_only),
    .rd_idx_i(rd_idx), .rd_off_i(rd_off), .rd_tag_i(rd_tag), .rd_ack_o(rd_ack),
    .mem_req_o(mem_req), .mem_tag_only_o(mem_tag_only), .mem_idx_o(mem_idx),
    .mem_off_o(mem_off), .mem_tag_o(mem_tag), .mem_ack_i(mem_ack)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      rd_idx[i] = 8'(8'h10 + i);
      rd_off[i] = 4'(i + 1);
      rd_tag[i] = 20'(20'hA0000 + i);
    end
    rst = 1; rd_req = 3'b111; rd_tag_only = 3'b010; mem_ack = 1;
    cyc();
    #1;
    chk("rst_ack", 32'(rd_ack), 0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_idx", 32'(mem_idx), 0);
    chk("rst_off", 32'(mem_off), 0);
    chk("rst_ptr", 32'(dut.rr_ptr_q), 0);
    cyc();
    rst = 0;
    #1;
    chk("post_rst_tag", 32'(mem_tag), 0);
    for (int k = 0; k < 6; k++) begin
      chk("rr_ack", 32'(rd_ack), 32'(1) << (k % 3));
      chk("rr_idx", 32'(mem_idx), 32'h10 + k % 3);
      chk("rr_off", 32'(mem_off), 32'(k % 3 + 1));
      if (k > 0) chk("rr_tag", 32'(mem_tag), 32'hA0000 + (k + 2) % 3);
      cyc();
    end
    chk("rr_ptr_wrap", 32'(dut.rr_ptr_q), 0);
    rd_req = 3'b010; mem_ack = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("wait_ack", 32'(rd_ack), 0);
      chk("wait_req", 32'(mem_req), 1);
      chk("wait_idx", 32'(mem_idx), 32'h11);
      chk("wait_tonly", 32'(mem_tag_only), 1);
      chk("wait_ptr", 32'(dut.rr_ptr_q), 0);
      cyc();
    end
    mem_ack = 1;
    #1;
    chk("late_ack", 32'(rd_ack), 32'b010);
    cyc();
    rd_req = 3'b000;
    #1;
    chk("late_ptr", 32'(dut.rr_ptr_q), 2);
    chk("late_tag", 32'(mem_tag), 32'hA0001);
    chk("idle_req", 32'(mem_req), 0);
    chk("idle_idx", 32'(mem_idx), 0);
    chk("idle_tonly", 32'(mem_tag_only), 0);
    rd_req = 3'b101;
    #1;
    chk("wrap_ack2", 32'(rd_ack), 32'b100);
    chk("wrap_tonly", 32'(mem_tag_only), 0);
    cyc();
    #1;
    chk("wrap_ack0", 32'(rd_ack), 32'b001);
    chk("wrap_tag2", 32'(mem_tag), 32'hA0002);
    cyc();
    rd_req = 3'b010;
    #1;
    chk("pre_rst_ptr", 32'(dut.rr_ptr_q), 1);
    chk("pre_rst_ack", 32'(rd_ack), 32'b010);
    cyc();
    rst = 1;
    #1;
    chk("mid_rst_ack", 32'(rd_ack), 0);
    chk("mid_rst_tag", 32'(mem_tag), 0);
    cyc();
    rst = 0; rd_req = 3'b000;
    #1;
    chk("after_rst_tag", 32'(mem_tag), 0);
    chk("after_rst_ptr", 32'(dut.rr_ptr_q), 0);
    mem_ack = 0;
    for (int k = 0; k < 3; k++) begin
      rd_req = (k == 1) ? 3'b100 : 3'b101;
      #1;
      chk("starve_wait", 32'(rd_ack), 0);
      cyc();
    end
    rd_req = 3'b101; mem_ack = 1;
    #1;
    chk("starve_win", 32'(rd_ack), 32'(STARVE_WIN));
    cyc();
    rd_req = 3'b000;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
